dualport_rom_reader: RTL and testbench

//  Read sequencer that sits directly upstream of dualport_rom. It drives a_addr/b_addr,

---
 rtl/dualport_rom_reader.sv | 190 +++++++++++++++++++
 tb/tb_dualport_rom_reader.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dualport_rom_reader.sv
// Read sequencer for a registered-read dual-port ROM; streams {A,B,idx} beats through a 2-entry FIFO.
// Optional per-port running sums on accepted beats when ACCUM_EN is defined.
module dualport_rom_reader #(
  parameter int AW = 4,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] a_base,
  input  logic [AW-1:0] b_base,
  input  logic [AW:0]   len,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  input  logic [DW-1:0] rom_dout_a,
  input  logic [DW-1:0] rom_dout_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  output logic [AW-1:0] out_idx,
  output logic          busy,
  output logic          done
`ifdef ACCUM_EN
  ,
  output logic [DW+AW:0] sum_a,
  output logic [DW+AW:0] sum_b
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  state_t        state_q, state_d;
  logic [AW-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic [AW:0]   rem_q, rem_d;
  logic          pend_q, pend_d;
  logic          rdv_q, rdv_d;
  logic [AW-1:0] cap_idx_q, cap_idx_d;
  logic [DW-1:0] fifo_a_q [2];
  logic [DW-1:0] fifo_a_d [2];
  logic [DW-1:0] fifo_b_q [2];
  logic [DW-1:0] fifo_b_d [2];
  logic [AW-1:0] fifo_i_q [2];
  logic [AW-1:0] fifo_i_d [2];
  logic          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          pop, room, cap, credit_ok;
  logic [AW:0]   len_eff;

  // pend: address on the ROM pins this cycle; rdv: ROM output holds an uncaptured beat.
  // rdv data stays valid while the address holds, so the ROM register acts as a third slot
  // and the credit check keeps FIFO + that slot within 3 so the FIFO never overflows.
  always_comb begin
    pop       = (cnt_q != 2'd0) & out_ready;
    room      = (cnt_q != 2'd2) | pop;
    cap       = rdv_q & room;
    cnt_d     = cnt_q - {1'b0, pop} + {1'b0, cap};
    rdv_d     = pend_q | (rdv_q & ~cap);
    credit_ok = ({1'b0, cnt_d} + {2'b00, rdv_d}) < 3'd3;
    len_eff   = (len > DEPTH) ? DEPTH : len;

    state_d   = state_q;
    a_addr_d  = a_addr_q;
    b_addr_d  = b_addr_q;
    rem_d     = rem_q;
    pend_d    = 1'b0;
    cap_idx_d = cap_idx_q;
    fifo_a_d  = fifo_a_q;
    fifo_b_d  = fifo_b_q;
    fifo_i_d  = fifo_i_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;

    if (cap) begin
      fifo_a_d[wr_ptr_q] = rom_dout_a;
      fifo_b_d[wr_ptr_q] = rom_dout_b;
      fifo_i_d[wr_ptr_q] = cap_idx_q;
      wr_ptr_d           = ~wr_ptr_q;
      cap_idx_d          = cap_idx_q + AW'(1);
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_d = FIN;
          end else begin
            // The first address goes out on the accepting edge itself.
            state_d   = ISSUE;
            a_addr_d  = a_base;
            b_addr_d  = b_base;
            pend_d    = 1'b1;
            rem_d     = len_eff - (AW+1)'(1);
            cap_idx_d = '0;
          end
        end
      end
      ISSUE: begin
        if (rem_q == '0) begin
          state_d = DRAIN;
        end else if (credit_ok) begin
          a_addr_d = a_addr_q + AW'(1);
          b_addr_d = b_addr_q + AW'(1);
          pend_d   = 1'b1;
          rem_d    = rem_q - (AW+1)'(1);
          if (rem_q == (AW+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!pend_q && !rdv_q && cnt_d == 2'd0) state_d = FIN;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_addr_q  <= '0;
      b_addr_q  <= '0;
      rem_q     <= '0;
      pend_q    <= 1'b0;
      rdv_q     <= 1'b0;
      cap_idx_q <= '0;
      fifo_a_q  <= '{default: '0};
      fifo_b_q  <= '{default: '0};
      fifo_i_q  <= '{default: '0};
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      a_addr_q  <= a_addr_d;
      b_addr_q  <= b_addr_d;
      rem_q     <= rem_d;
      pend_q    <= pend_d;
      rdv_q     <= rdv_d;
      cap_idx_q <= cap_idx_d;
      fifo_a_q  <= fifo_a_d;
      fifo_b_q  <= fifo_b_d;
      fifo_i_q  <= fifo_i_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign a_addr    = a_addr_q;
  assign b_addr    = b_addr_q;
  assign out_valid = (cnt_q != 2'd0);
  assign out_a     = fifo_a_q[rd_ptr_q];
  assign out_b     = fifo_b_q[rd_ptr_q];
  assign out_idx   = fifo_i_q[rd_ptr_q];
  assign busy      = (state_q == ISSUE) || (state_q == DRAIN);
  assign done      = (state_q == FIN);

`ifdef ACCUM_EN
  logic [DW+AW:0] sum_a_q, sum_a_d, sum_b_q, sum_b_d;

  always_comb begin
    sum_a_d = sum_a_q;
    sum_b_d = sum_b_q;
    if (state_q == IDLE && start) begin
      sum_a_d = '0;
      sum_b_d = '0;
    end else if (pop) begin
      sum_a_d = sum_a_q + (DW+AW+1)'(out_a);
      sum_b_d = sum_b_q + (DW+AW+1)'(out_b);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_a_q <= '0;
      sum_b_q <= '0;
    end else begin
      sum_a_q <= sum_a_d;
      sum_b_q <= sum_b_d;
    end
  end

  assign sum_a = sum_a_q;
  assign sum_b = sum_b_q;
`endif

endmodule

// File: tb/tb_dualport_rom_reader.sv
// Directed bench for dualport_rom_reader with a registered-read ROM model where ROM[i] = i.
// Build with ACCUM_EN defined to also check the running sums.
module tb_dualport_rom_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] a_base = '0;
  logic [3:0] b_base = '0;
  logic [4:0] len = '0;
  logic [3:0] a_addr, b_addr;
  logic [3:0] rom_dout_a, rom_dout_b;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_a, out_b, out_idx;
  logic       busy, done;
`ifdef ACCUM_EN
  logic [8:0] sum_a, sum_b;
`endif

  int errors = 0;
  int checks = 0;

  logic [3:0] got_a[$];
  logic [3:0] got_b[$];
  logic [3:0] got_i[$];
  logic [3:0] seq_a[$];
  logic [3:0] seq_b[$];
  int   first_valid_k, done_k, last_beat_k, done_width, ahead_err, stable_err;
  logic busy_k1;

  dualport_rom_reader #(.AW(4), .DW(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_base(a_base), .b_base(b_base), .len(len),
    .a_addr(a_addr), .b_addr(b_addr),
    .rom_dout_a(rom_dout_a), .rom_dout_b(rom_dout_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_idx(out_idx),
    .busy(busy), .done(done)
`ifdef ACCUM_EN
    , .sum_a(sum_a), .sum_b(sum_b)
`endif
  );

  always #5 clk = ~clk;

  // ROM[i] = i, one-cycle registered read
  always @(posedge clk) begin
    rom_dout_a <= a_addr;
    rom_dout_b <= b_addr;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Launches one burst and records beats, address sequence and timing (k = negedges after accept edge).
  task automatic run_burst(input logic [3:0] ab, input logic [3:0] bb, input logic [4:0] ln,
                           input int mode, input int glitch_k);
    int k, n_acc;
    logic prev_stall;
    logic [3:0] pa, pb, pi, la, lb;
    got_a.delete(); got_b.delete(); got_i.delete(); seq_a.delete(); seq_b.delete();
    first_valid_k = -1; done_k = -1; last_beat_k = -1;
    done_width = 0; ahead_err = 0; stable_err = 0; busy_k1 = 1'b0;
    k = 0; n_acc = 0; prev_stall = 1'b0;
    pa = '0; pb = '0; pi = '0; la = '0; lb = '0;
    @(negedge clk);
    start = 1'b1; a_base = ab; b_base = bb; len = ln;
    out_ready = (mode == 0);
    while (k < 200 && !(done_k >= 0 && k > done_k + 1)) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        start = 1'b0; a_base = 4'hF; b_base = 4'h7; len = 5'd2;
        busy_k1 = busy;
      end
      if (glitch_k > 0 && k == glitch_k) begin
        start = 1'b1; a_base = 4'd5; b_base = 4'd3; len = 5'd3;
      end
      if (glitch_k > 0 && k == glitch_k + 1) start = 1'b0;
      if (prev_stall && (!out_valid || out_a !== pa || out_b !== pb || out_idx !== pi))
        stable_err++;
      if (busy && (k == 1 || a_addr !== la || b_addr !== lb)) begin
        seq_a.push_back(a_addr); seq_b.push_back(b_addr);
        la = a_addr; lb = b_addr;
      end
      if (busy && (int'(4'(a_addr - ab)) - n_acc > 2)) ahead_err++;
      if (done) begin
        if (done_k < 0) done_k = k;
        done_width++;
      end
      out_ready = (mode == 0) ? 1'b1 : ((k % 3) == 1);
      if (out_valid && first_valid_k < 0) first_valid_k = k;
      if (out_valid && out_ready) begin
        got_a.push_back(out_a); got_b.push_back(out_b); got_i.push_back(out_idx);
        n_acc++;
        last_beat_k = k;
      end
      prev_stall = out_valid && !out_ready;
      pa = out_a; pb = out_b; pi = out_idx;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({a_addr, b_addr, out_valid, out_a, out_b, out_idx, busy, done} !== 23'd0) begin
      errors++;
      $display("FAIL reset_values: got %h required 0",
               {a_addr, b_addr, out_valid, out_a, out_b, out_idx, busy, done});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: got valid/busy/done=%b required 000", {out_valid, busy, done});
    end
    $display("test_reset: done");
  endtask

  task automatic test_basic();
    logic [11:0] exp_beat;
    run_burst(4'd0, 4'd8, 5'd8, 0, 0);
    checks++;
    if (got_a.size() != 8) begin
      errors++; $display("FAIL basic_count: got %0d required 8", got_a.size());
    end
    for (int i = 0; i < got_a.size() && i < 8; i++) begin
      exp_beat = {4'(i), 4'(8 + i), 4'(i)};
      checks++;
      if ({got_a[i], got_b[i], got_i[i]} !== exp_beat) begin
        errors++;
        $display("FAIL basic_beat%0d: got a=%0d b=%0d idx=%0d required a=%0d b=%0d idx=%0d",
                 i, got_a[i], got_b[i], got_i[i], exp_beat[11:8], exp_beat[7:4], exp_beat[3:0]);
      end
    end
    checks++;
    if (first_valid_k != 3) begin
      errors++; $display("FAIL basic_latency: first out_valid at k=%0d required k=3", first_valid_k);
    end
    checks++;
    if (done_k < 0 || done_k - last_beat_k != 1) begin
      errors++;
      $display("FAIL basic_done_timing: done_k=%0d last_beat_k=%0d required gap 1", done_k, last_beat_k);
    end
    checks++;
    if (done_width != 1) begin
      errors++; $display("FAIL basic_done_width: got %0d required 1", done_width);
    end
    checks++;
    if (busy_k1 !== 1'b1) begin
      errors++; $display("FAIL basic_busy: got %b required 1", busy_k1);
    end
`ifdef ACCUM_EN
    checks++;
    if (sum_a !== 9'd28 || sum_b !== 9'd92) begin
      errors++; $display("FAIL accum_sums: got %0d/%0d required 28/92", sum_a, sum_b);
    end
`endif
    $display("test_basic: beats=%0d first_valid_k=%0d done_k=%0d", got_a.size(), first_valid_k, done_k);
  endtask

  task automatic test_backpressure();
    logic [11:0] exp_beat;
    run_burst(4'd0, 4'd8, 5'd8, 1, 0);
    checks++;
    if (got_a.size() != 8) begin
      errors++; $display("FAIL bp_count: got %0d required 8", got_a.size());
    end
    for (int i = 0; i < got_a.size() && i < 8; i++) begin
      exp_beat = {4'(i), 4'(8 + i), 4'(i)};
      checks++;
      if ({got_a[i], got_b[i], got_i[i]} !== exp_beat) begin
        errors++;
        $display("FAIL bp_beat%0d: got %h required %h", i, {got_a[i], got_b[i], got_i[i]}, exp_beat);
      end
    end
    checks++;
    if (stable_err != 0) begin
      errors++; $display("FAIL bp_stable: got %0d unstable stall cycles required 0", stable_err);
    end
    checks++;
    if (ahead_err != 0) begin
      errors++; $display("FAIL bp_ahead: got %0d cycles >2 ahead required 0", ahead_err);
    end
    checks++;
    if (done_width != 1) begin
      errors++; $display("FAIL bp_done: got done width %0d required 1", done_width);
    end
    $display("test_backpressure: beats=%0d done_k=%0d", got_a.size(), done_k);
  endtask

  task automatic test_wrap();
    logic [3:0] ea[4];
    logic [3:0] eb[4];
    ea = '{4'd14, 4'd15, 4'd0, 4'd1};
    eb = '{4'd15, 4'd0, 4'd1, 4'd2};
    run_burst(4'd14, 4'd15, 5'd4, 0, 0);
    checks++;
    if (seq_a.size() != 4 || got_a.size() != 4) begin
      errors++;
      $display("FAIL wrap_count: got addrs=%0d beats=%0d required 4/4", seq_a.size(), got_a.size());
    end
    for (int i = 0; i < 4 && i < seq_a.size() && i < got_a.size(); i++) begin
      checks++;
      if (seq_a[i] !== ea[i] || seq_b[i] !== eb[i] || got_a[i] !== ea[i] || got_b[i] !== eb[i]
          || got_i[i] !== 4'(i)) begin
        errors++;
        $display("FAIL wrap_step%0d: got addr %0d/%0d data %0d/%0d idx %0d required %0d/%0d idx %0d",
                 i, seq_a[i], seq_b[i], got_a[i], got_b[i], got_i[i], ea[i], eb[i], i);
      end
    end
    $display("test_wrap: beats=%0d", got_a.size());
  endtask

  task automatic test_len_edges();
    run_burst(4'd5, 4'd6, 5'd0, 0, 0);
    checks++;
    if (got_a.size() != 0 || first_valid_k != -1) begin
      errors++; $display("FAIL len0_beats: got %0d beats required 0", got_a.size());
    end
    checks++;
    if (done_k != 1 || done_width != 1) begin
      errors++; $display("FAIL len0_done: got done_k=%0d width=%0d required 1/1", done_k, done_width);
    end
    run_burst(4'd3, 4'd0, 5'd20, 0, 0);
    checks++;
    if (got_a.size() != 16) begin
      errors++; $display("FAIL len20_count: got %0d required 16", got_a.size());
    end
    for (int i = 0; i < got_a.size() && i < 16; i++) begin
      checks++;
      if ({got_a[i], got_b[i], got_i[i]} !== {4'(3 + i), 4'(i), 4'(i)}) begin
        errors++;
        $display("FAIL len20_beat%0d: got %h required %h", i, {got_a[i], got_b[i], got_i[i]},
                 {4'(3 + i), 4'(i), 4'(i)});
      end
    end
    $display("test_len_edges: len20 beats=%0d", got_a.size());
  endtask

  task automatic test_ignore_and_midreset();
    int k, done_cnt;
    run_burst(4'd0, 4'd8, 5'd8, 0, 2);
    checks++;
    if (got_a.size() != 8) begin
      errors++; $display("FAIL glitch_count: got %0d required 8", got_a.size());
    end
    for (int i = 0; i < got_a.size() && i < 8; i++) begin
      checks++;
      if ({got_a[i], got_b[i], got_i[i]} !== {4'(i), 4'(8 + i), 4'(i)}) begin
        errors++;
        $display("FAIL glitch_beat%0d: got %h required %h", i, {got_a[i], got_b[i], got_i[i]},
                 {4'(i), 4'(8 + i), 4'(i)});
      end
    end
    // reset mid-burst while beat 3 is at the FIFO head
    @(negedge clk);
    start = 1'b1; a_base = 4'd0; b_base = 4'd8; len = 5'd8; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (k < 50 && !(out_valid && out_idx == 4'd3)) begin
      @(negedge clk); k++;
    end
    checks++;
    if (!(out_valid && out_idx == 4'd3)) begin
      errors++; $display("FAIL midreset_reach: beat 3 not seen within %0d cycles", k);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_addr, b_addr, out_valid, out_a, out_b, out_idx, busy, done} !== 23'd0) begin
      errors++;
      $display("FAIL midreset_values: got %h required 0",
               {a_addr, b_addr, out_valid, out_a, out_b, out_idx, busy, done});
    end
    done_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    checks++;
    if (done_cnt != 0) begin
      errors++; $display("FAIL midreset_nodone: got %0d done cycles required 0", done_cnt);
    end
    run_burst(4'd2, 4'd9, 5'd3, 0, 0);
    checks++;
    if (got_a.size() != 3) begin
      errors++; $display("FAIL after_reset_count: got %0d required 3", got_a.size());
    end
    for (int i = 0; i < got_a.size() && i < 3; i++) begin
      checks++;
      if ({got_a[i], got_b[i], got_i[i]} !== {4'(2 + i), 4'(9 + i), 4'(i)}) begin
        errors++;
        $display("FAIL after_reset_beat%0d: got %h required %h", i, {got_a[i], got_b[i], got_i[i]},
                 {4'(2 + i), 4'(9 + i), 4'(i)});
      end
    end
    $display("test_ignore_and_midreset: post-reset beats=%0d", got_a.size());
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_len_edges();
    test_ignore_and_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
